// File: rtl/data_mem_ctrl_if.sv
// Request/ready bus between the MEM stage (master) and the data memory controller (slave).
interface data_mem_ctrl_if #(
    parameter int unsigned WORD_LEN = 32
);
    logic                REQ;
    logic                WE;
    logic [1:0]          SIZE;
    logic                SIGNED;
    logic [WORD_LEN-1:0] ADDRESS;
    logic [WORD_LEN-1:0] DATA_IN;
    logic [WORD_LEN-1:0] DATA_OUT;
    logic                READY;
    logic                BUSY;
    logic                MISALIGN;

    modport master (
        output REQ, WE, SIZE, SIGNED, ADDRESS, DATA_IN,
        input  DATA_OUT, READY, BUSY, MISALIGN
    );

    modport slave (
        input  REQ, WE, SIZE, SIGNED, ADDRESS, DATA_IN,
        output DATA_OUT, READY, BUSY, MISALIGN
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// MIPS32 data memory: byte/half/word access, sign/zero-extended loads, programmable wait
// states, misalignment rejection and a clear sweep of the whole array after reset.
module data_mem_ctrl #(
    parameter int unsigned WORD_LEN    = 32,
    parameter int unsigned MEM_SIZE    = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic           CLK,
    input  logic           RESET,
    data_mem_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(MEM_SIZE);
    localparam int unsigned CW = 4;
    localparam int unsigned NL = WORD_LEN / 8;
    localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT} state_t;

    state_t              state, state_nxt;
    logic [AW-1:0]       clr_ptr;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic                accept, do_access, clr_en, mis_c;
    logic                ready_nxt, mis_nxt, busy_nxt;

    logic                lat_we, lat_sgn;
    logic [1:0]          lat_size;
    logic [AW+1:0]       lat_addr;
    logic [WORD_LEN-1:0] lat_din;

    logic                acc_we, acc_sgn;
    logic [1:0]          acc_size, lane;
    logic [AW+1:0]       acc_addr;
    logic [AW-1:0]       idx;
    logic [WORD_LEN-1:0] acc_din, rd_word, shifted, load_val, wdata;
    logic [NL-1:0]       be;
    logic                addr_unused;

    logic [WORD_LEN-1:0] mem [MEM_SIZE];

    assign addr_unused = ^bus.ADDRESS[WORD_LEN-1:AW+2];

    // Access operands: live inputs when accepting in IDLE, captured copies during WAIT.
    always_comb begin
        acc_we   = lat_we;
        acc_sgn  = lat_sgn;
        acc_size = lat_size;
        acc_addr = lat_addr;
        acc_din  = lat_din;
        if (state == ST_IDLE) begin
            acc_we   = bus.WE;
            acc_sgn  = bus.SIGNED;
            acc_size = bus.SIZE;
            acc_addr = bus.ADDRESS[AW+1:0];
            acc_din  = bus.DATA_IN;
        end
        lane    = acc_addr[1:0];
        idx     = acc_addr[AW+1:2];
        rd_word = mem[idx];
        shifted = rd_word >> {lane, 3'b000};
        wdata   = acc_din << {lane, 3'b000};
        mis_c   = (acc_size == 2'b11) ||
                  (acc_size == 2'b01 && acc_addr[0]) ||
                  (acc_size == 2'b10 && acc_addr[1:0] != 2'b00);
        unique case (acc_size)
            2'b00: begin
                load_val = {{(WORD_LEN-8){acc_sgn & shifted[7]}}, shifted[7:0]};
                be       = NL'(4'b0001 << lane);
            end
            2'b01: begin
                load_val = {{(WORD_LEN-16){acc_sgn & shifted[15]}}, shifted[15:0]};
                be       = NL'(4'b0011 << lane);
            end
            default: begin
                load_val = rd_word;
                be       = '1;
            end
        endcase
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        do_access = 1'b0;
        clr_en    = 1'b0;
        ready_nxt = 1'b0;
        mis_nxt   = 1'b0;
        busy_nxt  = bus.BUSY;
        unique case (state)
            ST_CLEAR: begin
                clr_en = 1'b1;
                if (clr_ptr == AW'(MEM_SIZE - 1)) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            ST_IDLE: begin
                if (bus.REQ) begin
                    accept = 1'b1;
                    if (mis_c) begin
                        ready_nxt = 1'b1;
                        mis_nxt   = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        do_access = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    do_access = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
        if (do_access) ready_nxt = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_CLEAR;
            clr_ptr      <= '0;
            cnt          <= '0;
            bus.DATA_OUT <= '0;
            bus.READY    <= 1'b0;
            bus.MISALIGN <= 1'b0;
            bus.BUSY     <= 1'b1;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            bus.READY    <= ready_nxt;
            bus.MISALIGN <= mis_nxt;
            bus.BUSY     <= busy_nxt;
            if (clr_en) clr_ptr <= clr_ptr + 1'b1;
            if (do_access && !acc_we) bus.DATA_OUT <= load_val;
            if (accept) begin
                lat_we   <= bus.WE;
                lat_sgn  <= bus.SIGNED;
                lat_size <= bus.SIZE;
                lat_addr <= bus.ADDRESS[AW+1:0];
                lat_din  <= bus.DATA_IN;
            end
        end
    end

    // Array writes are suppressed while RESET is high, so an aborted store never lands.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (clr_en) begin
                mem[clr_ptr] <= '0;
            end else if (do_access && acc_we) begin
                for (int k = 0; k < NL; k++)
                    if (be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (0 and 3 wait states) checked every cycle
// against a transaction-level memory model, plus directed literal expectations.
module tb_data_mem_ctrl;
    localparam int unsigned MS = 1024;

    logic              clk = 1'b0;
    logic [1:0]        rst, req, we, sgn;
    logic [1:0][1:0]   size;
    logic [1:0][31:0]  addr, din, dout;
    logic [1:0]        ready, busy, mis;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.WORD_LEN(32)) bus0 ();
    data_mem_ctrl_if #(.WORD_LEN(32)) bus1 ();

    assign bus0.REQ = req[0];  assign bus0.WE = we[0];  assign bus0.SIZE = size[0];
    assign bus0.SIGNED = sgn[0];  assign bus0.ADDRESS = addr[0];  assign bus0.DATA_IN = din[0];
    assign bus1.REQ = req[1];  assign bus1.WE = we[1];  assign bus1.SIZE = size[1];
    assign bus1.SIGNED = sgn[1];  assign bus1.ADDRESS = addr[1];  assign bus1.DATA_IN = din[1];
    assign dout[0] = bus0.DATA_OUT;  assign ready[0] = bus0.READY;
    assign busy[0] = bus0.BUSY;      assign mis[0]   = bus0.MISALIGN;
    assign dout[1] = bus1.DATA_OUT;  assign ready[1] = bus1.READY;
    assign busy[1] = bus1.BUSY;      assign mis[1]   = bus1.MISALIGN;

    data_mem_ctrl #(.WORD_LEN(32), .MEM_SIZE(MS), .WAIT_STATES(0)) dut0 (
        .CLK(clk), .RESET(rst[0]), .bus(bus0));
    data_mem_ctrl #(.WORD_LEN(32), .MEM_SIZE(MS), .WAIT_STATES(3)) dut1 (
        .CLK(clk), .RESET(rst[1]), .bus(bus1));

    function automatic int ws(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic logic f_mis(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [9:0] widx(input logic [31:0] a);
        return a[11:2];
    endfunction

    function automatic logic [31:0] f_store(input logic [31:0] old, input logic [1:0] s,
                                           input logic [1:0] ln, input logic [31:0] d);
        logic [31:0] m;
        m = (s == 2'd0) ? 32'h0000_00FF : (s == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        m = m << (8 * ln);
        return (old & ~m) | ((d << (8 * ln)) & m);
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] s,
                                          input logic [1:0] ln, input logic sg);
        logic [31:0] v;
        v = w >> (8 * ln);
        if (s == 2'd0) return sg ? 32'(signed'(v[7:0])) : {24'd0, v[7:0]};
        if (s == 2'd1) return sg ? 32'(signed'(v[15:0])) : {16'd0, v[15:0]};
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one transaction at a time, performed WS edges after acceptance.
    int unsigned       cyc = 0;
    logic [31:0]       m_mem [2][MS];
    int                m_sweep [2];
    logic [1:0]        m_ready, m_mis, p_valid, p_we, p_sgn;
    logic [1:0][31:0]  m_dout, p_addr, p_din;
    logic [1:0][1:0]   p_size;
    int unsigned       p_due [2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            m_ready[i] <= 1'b0;
            m_mis[i]   <= 1'b0;
            if (rst[i]) begin
                m_sweep[i] <= MS;
                p_valid[i] <= 1'b0;
                m_dout[i]  <= '0;
                for (int j = 0; j < MS; j++) m_mem[i][j] <= '0;
            end else if (m_sweep[i] > 0) begin
                m_sweep[i] <= m_sweep[i] - 1;
            end else if (p_valid[i]) begin
                if (cyc == p_due[i]) begin
                    p_valid[i] <= 1'b0;
                    m_ready[i] <= 1'b1;
                    if (p_we[i])
                        m_mem[i][widx(p_addr[i])] <= f_store(m_mem[i][widx(p_addr[i])],
                                                             p_size[i], p_addr[i][1:0], p_din[i]);
                    else
                        m_dout[i] <= f_load(m_mem[i][widx(p_addr[i])], p_size[i],
                                            p_addr[i][1:0], p_sgn[i]);
                end
            end else if (req[i]) begin
                if (f_mis(size[i], addr[i])) begin
                    m_ready[i] <= 1'b1;
                    m_mis[i]   <= 1'b1;
                end else if (ws(i) == 0) begin
                    m_ready[i] <= 1'b1;
                    if (we[i])
                        m_mem[i][widx(addr[i])] <= f_store(m_mem[i][widx(addr[i])],
                                                           size[i], addr[i][1:0], din[i]);
                    else
                        m_dout[i] <= f_load(m_mem[i][widx(addr[i])], size[i],
                                            addr[i][1:0], sgn[i]);
                end else begin
                    p_valid[i] <= 1'b1;
                    p_due[i]   <= cyc + ws(i);
                    p_we[i]    <= we[i];
                    p_sgn[i]   <= sgn[i];
                    p_size[i]  <= size[i];
                    p_addr[i]  <= addr[i];
                    p_din[i]   <= din[i];
                end
            end
        end
    end

    // Every cycle: BUSY, READY, MISALIGN and DATA_OUT of both instances against the model.
    always @(negedge clk) begin
        if (cyc > 0)
            for (int i = 0; i < 2; i++)
                chk($sformatf("outs%0d {busy,ready,mis,dout}", i),
                    64'({busy[i], ready[i], mis[i], dout[i]}),
                    64'({m_sweep[i] != 0, m_ready[i], m_mis[i], m_dout[i]}));
    end

    // Issue one request at a negedge with the DUT idle; return at the negedge READY is seen.
    task automatic xfer(input int i, input logic w, input logic [1:0] s, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic ms);
        req[i] = 1'b1; we[i] = w; size[i] = s; sgn[i] = sg; addr[i] = a; din[i] = d;
        lat = 0; rd = '0; ms = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) req[i] = 1'b0;
            if (ready[i]) begin
                lat = n; rd = dout[i]; ms = mis[i];
                break;
            end
            addr[i] = $urandom; din[i] = $urandom; we[i] = 1'($urandom); size[i] = 2'($urandom);
        end
        if (lat == 0) chk($sformatf("ready_timeout%0d", i), 64'(ready[i]), 64'd1);
    endtask

    task automatic wait_sweep(input int i, output int bc, output int rc);
        bc = 0; rc = 0;
        for (int n = 0; n < 1200 && busy[i]; n++) begin
            bc++;
            if (ready != 2'b00) rc++;
            req  = (n < 1000) ? 2'($urandom) : 2'b00;
            we   = 2'($urandom); sgn = 2'($urandom);
            size = 4'($urandom); addr = 64'({$urandom, $urandom}); din = 64'({$urandom, $urandom});
            @(negedge clk);
        end
    endtask

    int          lat, bc, rc;
    logic [31:0] rd, ra;
    logic        ms, rw, rs;
    logic [1:0]  rz;

    initial begin
        rst = 2'b11; req = '0; we = '0; sgn = '0; size = '0; addr = '0; din = '0;
        repeat (2) @(negedge clk);
        rst = 2'b00;

        // Clear sweep with random requests that must be ignored
        wait_sweep(0, bc, rc);
        chk("busy_cycles", 64'(bc), 64'd1024);
        chk("sweep_ready_count", 64'(rc), 64'd0);
        xfer(0, 1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, lat, rd, ms);
        chk("lw_word0_after_clear", 64'(rd), 64'h0);
        xfer(0, 1'b0, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0, lat, rd, ms);
        chk("lw_word1023_after_clear", 64'(rd), 64'h0);

        // Zero wait states, back-to-back requests
        xfer(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, ms);
        chk("sw_latency_ws0", 64'(lat), 64'd1);
        xfer(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, ms);
        chk("lw_latency_ws0", 64'(lat), 64'd1);
        chk("lw_deadbeef", 64'(rd), 64'hDEAD_BEEF);

        // Byte/half lanes and extension
        xfer(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, lat, rd, ms);
        xfer(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080, lat, rd, ms);
        xfer(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, ms);
        chk("sb_merge_word", 64'(rd), 64'h8022_3344);
        chk("model_word4", 64'(m_mem[0][4]), 64'h8022_3344);
        xfer(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, lat, rd, ms);
        chk("lb_signed", 64'(rd), 64'hFFFF_FF80);
        xfer(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, lat, rd, ms);
        chk("lbu", 64'(rd), 64'h0000_0080);
        xfer(0, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, lat, rd, ms);
        chk("lh_signed", 64'(rd), 64'hFFFF_8022);

        // Misaligned requests are rejected without side effects
        xfer(0, 1'b0, 2'd2, 1'b0, 32'h02, 32'h0, lat, rd, ms);
        chk("lw_mis_flag", 64'(ms), 64'd1);
        chk("lw_mis_dout_kept", 64'(rd), 64'hFFFF_8022);
        xfer(0, 1'b0, 2'd1, 1'b0, 32'h01, 32'h0, lat, rd, ms);
        chk("lh_mis_flag", 64'(ms), 64'd1);
        xfer(0, 1'b1, 2'd3, 1'b0, 32'h10, 32'h5555_5555, lat, rd, ms);
        chk("size3_mis_flag", 64'(ms), 64'd1);
        xfer(0, 1'b1, 2'd2, 1'b0, 32'h12, 32'h0, lat, rd, ms);
        xfer(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, ms);
        chk("mis_mem_kept", 64'(rd), 64'h8022_3344);
        chk("aligned_mis_clear", 64'(ms), 64'd0);

        // Three wait states: latency, operand capture, address wrap
        xfer(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, lat, rd, ms);
        chk("sw_latency_ws3", 64'(lat), 64'd4);
        xfer(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, rd, ms);
        chk("lw_latency_ws3", 64'(lat), 64'd4);
        chk("lw_ws3_capture", 64'(rd), 64'h1234_5678);
        xfer(1, 1'b1, 2'd2, 1'b0, 32'(4 * MS + 8), 32'hA5A5_0001, lat, rd, ms);
        xfer(1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, lat, rd, ms);
        chk("alias_word2", 64'(rd), 64'hA5A5_0001);
        xfer(1, 1'b0, 2'd1, 1'b0, 32'h23, 32'h0, lat, rd, ms);
        chk("mis_latency_ws3", 64'(lat), 64'd1);

        // Random traffic on both instances, latency checked from the access rules
        for (int t = 0; t < 300; t++) begin
            int i;
            i  = t % 2;
            rw = 1'($urandom); rs = 1'($urandom); rz = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) << 12) | $urandom_range(0, 63);
            xfer(i, rw, rz, rs, ra, $urandom, lat, rd, ms);
            chk($sformatf("rand_latency%0d", i), 64'(lat),
                64'(f_mis(rz, ra) ? 1 : ws(i) + 1));
        end

        // Reset during the wait of a pending store aborts it
        req[1] = 1'b1; we[1] = 1'b1; size[1] = 2'd2; addr[1] = 32'h40; din[1] = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk); req[1] = 1'b0;
        @(negedge clk); rst[1] = 1'b1;
        @(negedge clk); rst[1] = 1'b0;
        wait_sweep(1, bc, rc);
        chk("reset_busy_cycles", 64'(bc), 64'd1024);
        xfer(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, lat, rd, ms);
        chk("aborted_store_reads0", 64'(rd), 64'h0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end
endmodule
